// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round count and the
// round-controller state encoding.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    RUN,
    DONE
  } aes_ctrl_st_e;

endpackage

// File: rtl/aes_dp_timer.sv
// Loadable down-counter that times the external round datapath.
// expire_o flags the final cycle of the wait window.
module aes_dp_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(LAT + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TW'(LAT);
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == TW'(1));

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encrypt sequencer: owns cipher state and round
// counter, fetches round keys and steps the external round datapath.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES128_NR,
  parameter int DP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AES_BLK_W-1:0] in_data_i,
  output logic                 key_req_o,
  output logic [3:0]           key_round_o,
  input  logic                 key_ack_i,
  input  logic [AES_BLK_W-1:0] rk_in_i,
  output logic                 dp_start_o,
  output logic [AES_BLK_W-1:0] dp_state_o,
  output logic [AES_BLK_W-1:0] dp_rk_o,
  output logic                 dp_last_o,
  input  logic [AES_BLK_W-1:0] dp_result_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AES_BLK_W-1:0] out_data_o,
  output logic                 busy_o
);

  localparam int RW = $clog2(NR + 1);

  aes_ctrl_st_e         st_q, st_d;
  logic [RW-1:0]        round_q, round_d;
  logic [AES_BLK_W-1:0] state_q, state_d;
  logic [AES_BLK_W-1:0] rk_q, rk_d;
  logic                 start_q, start_d;
  logic                 tmr_load;
  logic                 tmr_exp;
  logic                 run;

  assign run = (st_q == RUN);

  aes_dp_timer #(
    .LAT(DP_LAT)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .en_i    (run),
    .expire_o(tmr_exp)
  );

  always_comb begin
    st_d     = st_q;
    round_d  = round_q;
    state_d  = state_q;
    rk_d     = rk_q;
    start_d  = 1'b0;
    tmr_load = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = in_data_i;
          round_d = '0;
          st_d    = KEY;
        end
      end
      KEY: begin
        if (key_ack_i) begin
          rk_d = rk_in_i;
          // Round 0 is the bare AddRoundKey; no datapath pass.
          if (round_q == '0) begin
            state_d = state_q ^ rk_in_i;
            round_d = RW'(1);
          end else begin
            st_d     = RUN;
            start_d  = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (tmr_exp) begin
          state_d = dp_result_i;
          if (round_q == RW'(NR)) begin
            st_d = DONE;
          end else begin
            round_d = round_q + RW'(1);
            st_d    = KEY;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      round_q <= '0;
      state_q <= '0;
      rk_q    <= '0;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      start_q <= start_d;
    end
  end

  assign in_ready_o  = (st_q == IDLE);
  assign key_req_o   = (st_q == KEY);
  assign key_round_o = 4'(round_q);
  assign dp_start_o  = start_q;
  assign dp_state_o  = state_q;
  assign dp_rk_o     = rk_q;
  assign dp_last_o   = run && (round_q == RW'(NR));
  assign out_valid_o = (st_q == DONE);
  assign out_data_o  = state_q;
  assign busy_o      = (st_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with behavioural key schedule
// and round datapath; a second instance runs with DP_LAT=3.
module tb_aes_round_ctrl;

  localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk, rst;
  logic in_valid, in_ready, key_req, key_ack, dp_start, dp_last;
  logic out_valid, out_ready, busy;
  logic [3:0] key_round;
  logic [127:0] in_data, rk_in, dp_state, dp_rk, dp_result, out_data;

  logic in_valid3, in_ready3, key_req3, key_ack3, dp_start3, dp_last3;
  logic out_valid3, out_ready3, busy3;
  logic [3:0] key_round3;
  logic [127:0] in_data3, rk_in3, dp_state3, dp_rk3, dp_result3, out_data3;

  logic [127:0] rk_sched [16];

  int vecs = 0;
  int errs = 0;

  logic [127:0] ct;
  int lat, caps, seq_err, seq_n, hold_err, wtot;
  bit tmo;

  aes_round_ctrl #(.NR(10), .DP_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .key_req_o(key_req), .key_round_o(key_round),
    .key_ack_i(key_ack), .rk_in_i(rk_in),
    .dp_start_o(dp_start), .dp_state_o(dp_state), .dp_rk_o(dp_rk),
    .dp_last_o(dp_last), .dp_result_i(dp_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .busy_o(busy)
  );

  aes_round_ctrl #(.NR(10), .DP_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_data_i(in_data3),
    .key_req_o(key_req3), .key_round_o(key_round3),
    .key_ack_i(key_ack3), .rk_in_i(rk_in3),
    .dp_start_o(dp_start3), .dp_state_o(dp_state3), .dp_rk_o(dp_rk3),
    .dp_last_o(dp_last3), .dp_result_i(dp_result3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3),
    .out_data_o(out_data3), .busy_o(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gm(r, r);
      if (e[i]) r = gm(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st,
                                             input logic [127:0] rk,
                                             input logic last);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = s[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

  assign rk_in      = rk_sched[key_round];
  assign rk_in3     = rk_sched[key_round3];
  assign dp_result  = aes_round(dp_state, dp_rk, dp_last);
  assign dp_result3 = aes_round(dp_state3, dp_rk3, dp_last3);

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])}
            ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk_sched[r] = '0;
  endtask

  // Drives one block into dut; maxd<0 ties key_ack high, else random
  // 0..maxd cycle ack delay per round. Returns at the first out_valid.
  task automatic encrypt(input logic [127:0] pt, input logic [127:0] key,
                         input int maxd, input bit spam,
                         output logic [127:0] o_ct, output int o_lat,
                         output int o_caps, output int o_seq_err,
                         output int o_seq_n, output int o_hold_err,
                         output int o_wtot, output bit o_tmo);
    int dly, wcnt;
    bit need_new;
    logic [3:0] hold_r;
    expand(key);
    o_ct = '0; o_lat = 0; o_caps = 1; o_seq_err = 0; o_seq_n = 0;
    o_hold_err = 0; o_wtot = 0; o_tmo = 1'b1;
    need_new = 1'b1; dly = 0; wcnt = 0; hold_r = '0;
    in_data = pt;
    in_valid = 1'b1;
    key_ack = (maxd < 0);
    @(posedge clk); #1;
    if (spam) in_data = ~pt;
    else in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (out_valid) begin
        o_ct = out_data;
        o_lat = n;
        o_tmo = 1'b0;
        break;
      end
      if (in_valid && in_ready) o_caps++;
      if (key_req) begin
        if (need_new) begin
          if (key_round != o_seq_n[3:0]) o_seq_err++;
          o_seq_n++;
          hold_r = key_round;
          need_new = 1'b0;
          wcnt = 0;
          dly = (maxd < 0) ? 0 : int'($urandom_range(0, maxd));
        end else if (key_round !== hold_r) begin
          o_hold_err++;
        end
        if (maxd < 0 || wcnt >= dly) begin
          key_ack = 1'b1;
          need_new = 1'b1;
        end else begin
          key_ack = 1'b0;
          wcnt++;
          o_wtot++;
        end
      end else begin
        key_ack = (maxd < 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    key_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1; in_data = PT_FIPS; key_ack = 1'b1; out_ready = 1'b1;
    in_valid3 = 1'b0; in_data3 = '0; key_ack3 = 1'b0; out_ready3 = 1'b0;
    expand('0);
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({in_ready, busy, key_req, out_valid, dp_start, dp_last, key_round} !== 10'h200) begin
      errs++;
      $display("FAIL rst_ctl got %b exp %b",
        {in_ready, busy, key_req, out_valid, dp_start, dp_last, key_round}, 10'h200);
    end
    vecs++;
    if ({out_data, dp_state, dp_rk} !== 384'h0) begin
      errs++;
      $display("FAIL rst_data got %h/%h exp 0", out_data, dp_rk);
    end
    in_valid = 1'b0; key_ack = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if ({in_ready, busy, in_ready3, busy3} !== 4'b1010) begin
      errs++;
      $display("FAIL rst_idle got %b exp 1010", {in_ready, busy, in_ready3, busy3});
    end
  endtask

  task automatic test_fips_latency;
    out_ready = 1'b1;
    encrypt(PT_FIPS, K_FIPS, -1, 1'b0, ct, lat, caps, seq_err, seq_n, hold_err, wtot, tmo);
    vecs++;
    if (tmo) begin errs++; $display("FAIL fips_timeout got no out_valid exp done"); end
    vecs++;
    if (ct !== CT_FIPS) begin errs++; $display("FAIL fips_ct got %h exp %h", ct, CT_FIPS); end
    vecs++;
    if (lat != 21) begin errs++; $display("FAIL fips_latency got %0d exp 21", lat); end
    vecs++;
    if (seq_n != 11 || seq_err != 0) begin
      errs++;
      $display("FAIL fips_key_seq got n=%0d err=%0d exp n=11 err=0", seq_n, seq_err);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errs++;
      $display("FAIL fips_handshake got %b exp 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_key_backoff;
    out_ready = 1'b0;
    encrypt(PT_FIPS, K_FIPS, 5, 1'b0, ct, lat, caps, seq_err, seq_n, hold_err, wtot, tmo);
    vecs++;
    if (tmo) begin errs++; $display("FAIL backoff_timeout got no out_valid exp done"); end
    vecs++;
    if (ct !== CT_FIPS) begin errs++; $display("FAIL backoff_ct got %h exp %h", ct, CT_FIPS); end
    vecs++;
    if (seq_n != 11 || seq_err != 0) begin
      errs++;
      $display("FAIL backoff_key_seq got n=%0d err=%0d exp n=11 err=0", seq_n, seq_err);
    end
    vecs++;
    if (hold_err != 0) begin errs++; $display("FAIL backoff_round_hold got %0d exp 0", hold_err); end
    vecs++;
    if (lat != 21 + wtot) begin
      errs++;
      $display("FAIL backoff_latency got %0d exp %0d", lat, 21 + wtot);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      vecs++;
      if ({out_valid, in_ready, out_data} !== {2'b10, CT_FIPS}) begin
        errs++;
        $display("FAIL bp_hold cyc %0d got v=%b r=%b d=%h exp v=1 r=0 d=%h",
          i, out_valid, in_ready, out_data, CT_FIPS);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errs++;
      $display("FAIL bp_release got %b exp 100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_in_valid_spam;
    out_ready = 1'b0;
    encrypt(PT_FIPS, K_FIPS, 2, 1'b1, ct, lat, caps, seq_err, seq_n, hold_err, wtot, tmo);
    vecs++;
    if (ct !== CT_FIPS || tmo) begin
      errs++;
      $display("FAIL spam_ct got %h exp %h", ct, CT_FIPS);
    end
    vecs++;
    if (caps != 1) begin errs++; $display("FAIL spam_captures got %0d exp 1", caps); end
    in_valid = 1'b1;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({out_valid, in_ready, out_data} !== {2'b10, CT_FIPS}) begin
      errs++;
      $display("FAIL spam_done_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, CT_FIPS);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL spam_idle got %b exp 1", in_ready); end
    encrypt('0, '0, -1, 1'b0, ct, lat, caps, seq_err, seq_n, hold_err, wtot, tmo);
    vecs++;
    if (ct !== CT_ZERO || tmo) begin
      errs++;
      $display("FAIL spam_second_ct got %h exp %h", ct, CT_ZERO);
    end
    vecs++;
    if (lat != 21) begin errs++; $display("FAIL spam_second_latency got %0d exp 21", lat); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    bit found;
    found = 1'b0;
    expand(K_FIPS);
    in_data = PT_FIPS;
    in_valid = 1'b1;
    key_ack = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (dp_start && key_round == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (!found) begin errs++; $display("FAIL arst_reach_r5 got none exp dp_start in round 5"); end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({in_ready, busy, key_req, out_valid, dp_start, dp_last, key_round} !== 10'h200) begin
      errs++;
      $display("FAIL arst_ctl got %b exp %b",
        {in_ready, busy, key_req, out_valid, dp_start, dp_last, key_round}, 10'h200);
    end
    vecs++;
    if ({out_data, dp_state, dp_rk} !== 384'h0) begin
      errs++;
      $display("FAIL arst_data got %h/%h exp 0", dp_state, dp_rk);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    key_ack = 1'b0;
    encrypt('0, '0, 3, 1'b0, ct, lat, caps, seq_err, seq_n, hold_err, wtot, tmo);
    vecs++;
    if (ct !== CT_ZERO || tmo) begin
      errs++;
      $display("FAIL arst_next_ct got %h exp %h", ct, CT_ZERO);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_lat3;
    int n3, starts, lastc, lastbad, hbad;
    bit done3;
    logic [127:0] cap_s, cap_r, ct3;
    n3 = 0; starts = 0; lastc = 0; lastbad = 0; hbad = 0; done3 = 1'b0;
    cap_s = '0; cap_r = '0; ct3 = '0;
    expand(K_FIPS);
    in_data3 = PT_FIPS;
    in_valid3 = 1'b1;
    key_ack3 = 1'b1;
    out_ready3 = 1'b0;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (out_valid3) begin
        n3 = n; ct3 = out_data3; done3 = 1'b1;
        break;
      end
      if (dp_start3) begin
        starts++;
        cap_s = dp_state3;
        cap_r = dp_rk3;
      end else if (busy3 && !key_req3) begin
        if (dp_state3 !== cap_s || dp_rk3 !== cap_r) hbad++;
      end
      if (dp_last3) begin
        lastc++;
        if (key_round3 != 4'd10) lastbad++;
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (!done3) begin errs++; $display("FAIL lat3_timeout got no out_valid exp done"); end
    vecs++;
    if (n3 != 41) begin errs++; $display("FAIL lat3_latency got %0d exp 41", n3); end
    vecs++;
    if (starts != 10) begin errs++; $display("FAIL lat3_dp_start got %0d exp 10", starts); end
    vecs++;
    if (lastc != 3 || lastbad != 0) begin
      errs++;
      $display("FAIL lat3_dp_last got cyc=%0d bad=%0d exp cyc=3 bad=0", lastc, lastbad);
    end
    vecs++;
    if (hbad != 0) begin errs++; $display("FAIL lat3_run_hold got %0d exp 0", hbad); end
    vecs++;
    if (ct3 !== CT_FIPS) begin errs++; $display("FAIL lat3_ct got %h exp %h", ct3, CT_FIPS); end
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
    key_ack3 = 1'b0;
    vecs++;
    if ({in_ready3, busy3} !== 2'b10) begin
      errs++;
      $display("FAIL lat3_idle got %b exp 10", {in_ready3, busy3});
    end
  endtask

  initial begin
    test_reset();
    test_fips_latency();
    test_key_backoff();
    test_backpressure();
    test_in_valid_spam();
    test_async_reset();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
